// File: rtl/csa3_resolver.sv
// Resolves the redundant (sum, carry, carry-out) vectors of a 4:3 compressor row
// into a binary result, CHUNK bits per cycle, with valid/ready on both sides.
module csa3_resolver #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   s_vec,
  input  logic [WIDTH-1:0]   c_vec,
  input  logic [WIDTH-1:0]   o_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+2:0]   result
);

  localparam int RW  = WIDTH + 3;
  localparam int NCH = (RW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = CHUNK + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, b_q, c_q, acc_q;
  logic [IW-1:0]   idx_q;
  logic [1:0]      carry_q;
  logic [SW-1:0]   chunk_sum;
  int              base;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)          state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q[RW-1:0];

  // Three CHUNK-bit slices plus a carry of at most 2 stay below 2^(CHUNK+2).
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    chunk_sum = SW'(a_q[base +: CHUNK]) + SW'(b_q[base +: CHUNK])
              + SW'(c_q[base +: CHUNK]) + SW'(carry_q);
  end

  // NOTE: operand registers carry no reset; they are loaded before any use and rst only needs control state.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      a_q[WIDTH-1:0]   <= s_vec;
      b_q[WIDTH:1]     <= c_vec;
      c_q[WIDTH+1:2]   <= o_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= '0;
          end
        end
        RUN: begin
          acc_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q              <= chunk_sum[SW-1:CHUNK];
          idx_q                <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Padding bits above the result width can never be set, since 7*(2^WIDTH-1) fits in RW bits.
  generate
    if (PW > RW) begin : g_pad_check
      pad_zero_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == DONE) |-> (acc_q[PW-1:RW] == '0));
    end
  endgenerate

endmodule

// File: tb/tb_csa3_resolver.sv
// Directed bench for csa3_resolver: reset, arithmetic vectors, latency,
// backpressure, back-to-back operation and reset in the middle of a run.
module tb_csa3_resolver;

  localparam int WIDTH = 24;
  localparam int RW    = WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_vec, c_vec, o_vec;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csa3_resolver #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_vec     (s_vec),
    .c_vec     (c_vec),
    .o_vec     (o_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction starting in IDLE, 1 time unit after an edge.
  task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input logic [WIDTH-1:0] o, input logic [RW-1:0] exp,
                        input string tag);
    int cyc;
    s_vec = s; c_vec = c; o_vec = o; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    s_vec = 24'hA5A5A5; c_vec = 24'h5A5A5A; o_vec = 24'h3C3C3C;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: in_ready=%b out_valid=%b want 0 0", tag, in_ready, out_valid);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    total++;
    if (cyc !== 4) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles want 4", tag, cyc);
    end
    total++;
    if (result !== exp) begin
      bad++;
      $display("FAIL %s result: got 0x%07h want 0x%07h", tag, result, exp);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s in_ready in DONE: got %b want 0", tag, in_ready);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=0x%07h want 1 0 0",
               in_ready, out_valid, result);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    run_op(24'h000000, 24'h000000, 24'h000000, 27'h0000000, "zero");
  endtask

  task automatic test_ones();
    run_op(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 27'h6FFFFF9, "ones");
  endtask

  task automatic test_top_align();
    run_op(24'h000000, 24'h000000, 24'h800000, 27'h2000000, "top_o");
    run_op(24'h800000, 24'h800000, 24'h000000, 27'h1800000, "top_sc");
  endtask

  task automatic test_chunk_carry();
    run_op(24'h0000FF, 24'h000080, 24'h000040, 27'h00002FF, "chunk_carry");
    run_op(24'h123456, 24'h0F0F0F, 24'h00FF00, 27'h0344E74, "mixed");
  endtask

  task automatic test_backpressure();
    int cyc;
    s_vec = 24'h00FFFF; c_vec = 24'h000001; o_vec = 24'h000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    total++;
    if (out_valid !== 1'b1 || result !== 27'h0010005) begin
      bad++;
      $display("FAIL bp first: out_valid=%b result=0x%07h want 1 0x0010005", out_valid, result);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        s_vec = 24'hFFFFFF; c_vec = 24'hFFFFFF; o_vec = 24'hFFFFFF; in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 27'h0010005 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp hold %0d: out_valid=%b result=0x%07h in_ready=%b want 1 0x0010005 0",
                 i, out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_op(24'h123456, 24'h0F0F0F, 24'h00FF00, 27'h0344E74, "b2b_1");
    run_op(24'h0000FF, 24'h000080, 24'h000040, 27'h00002FF, "b2b_2");
  endtask

  task automatic test_reset_mid_run();
    s_vec = 24'hFFFFFF; c_vec = 24'hFFFFFF; o_vec = 24'hFFFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (result !== 27'h00000F9 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_run partial: result=0x%07h out_valid=%b in_ready=%b want 0x00000F9 0 0",
               result, out_valid, in_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL mid_run reset: in_ready=%b out_valid=%b result=0x%07h want 1 0 0",
               in_ready, out_valid, result);
    end
    run_op(24'h000001, 24'h000001, 24'h000001, 27'h0000007, "after_reset");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s_vec = '0; c_vec = '0; o_vec = '0;
    test_reset();
    test_zero();
    test_ones();
    test_top_align();
    test_chunk_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
